adc_dual_capture: RTL and testbench

//  Upstream front end of the wind-direction datapath. Drives a dual-channel simultaneous-sampling
//  SPI ADC (one CS/SCLK, two MISO lines) at a fixed sample rate. Deserialises both 12-bit results
//  and presents them as rx1/rx2 with a one-cycle endata strobe, which is what the real2cpx pair consumes.

---
 rtl/wind_pkg.sv | 8 +
 rtl/spi_sclk_gen.sv | 47 ++++
 rtl/adc_dual_capture.sv | 160 ++++++++++++++++
 tb/tb_adc_dual_capture.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wind_pkg.sv
// wind_pkg: shared constants and ADC capture FSM states for the wind-direction datapath.
// Provides ADC_FRAME_BITS (SPI frame length), ADC_DATA_W (ADC result width) and the
// capture FSM state type adc_state_e {IDLE, SETUP, SHIFT, HOLD}.
package wind_pkg;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_W = 12;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} adc_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: CPOL=1 SPI clock divider for the dual ADC capture block.
// Ports: clock/reset (async active-high); en keeps the divider running, low forces sclk
// high and rewinds the phase counter; sclk toggles every CLK_DIV cycles while enabled;
// fall/rise are single-cycle strobes aligned with the first cycle of each new sclk level.
module spi_sclk_gen
    import wind_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic fall,
    output logic rise
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic sclk_q, sclk_d, fall_q, fall_d, rise_q, rise_d, wrap;

    always_comb begin
        wrap = cnt_q == CW'(CLK_DIV - 1);
        cnt_d = !en || wrap ? '0 : cnt_q + 1'b1;
        sclk_d = !en ? 1'b1 : (wrap ? ~sclk_q : sclk_q);
        fall_d = en && wrap && sclk_q;
        rise_d = en && wrap && !sclk_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sclk_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sclk_q <= sclk_d;
            fall_q <= fall_d;
            rise_q <= rise_d;
        end
    end

    assign sclk = sclk_q;
    assign fall = fall_q;
    assign rise = rise_q;
endmodule

// File: rtl/adc_dual_capture.sv
// adc_dual_capture: drives a dual-channel simultaneous-sampling SPI ADC at a fixed sample
// rate and deserialises both 12-bit results into rx1/rx2 with a one-cycle endata strobe.
// Ports: clock, reset (async active-high), run (enable sample timer), adc_cs_n/adc_sclk
// (SPI master outputs, CPOL=1), adc_miso1/2 (serial data), rx1/rx2 (last good samples),
// endata (rx updated), frame_err (non-zero leading bits, frame dropped), overrun (sticky,
// tick arrived while busy; cleared by run=0).
// Optional feature macro ADC_SYNC_EN: 2-flop synchronisers on miso; all captures, strobes
// and the cs_n rise move 2 cycles later. CHECK_PERIOD=0 disables the sample-period check.
module adc_dual_capture
    import wind_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int DATA_W = ADC_DATA_W,
    parameter bit CHECK_PERIOD = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_miso1,
    input  logic              adc_miso2,
    output logic [DATA_W-1:0] rx1,
    output logic [DATA_W-1:0] rx2,
    output logic              endata,
    output logic              frame_err,
    output logic              overrun
);
    localparam int FB = ADC_FRAME_BITS;
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int BW = $clog2((CLK_DIV > FB ? CLK_DIV : FB) + 1);
`ifdef ADC_SYNC_EN
    localparam int MIN_DIV = 3;
`else
    localparam int MIN_DIV = 2;
`endif

    generate
        if (CLK_DIV < MIN_DIV) begin : g_bad_div
            $error("adc_dual_capture: CLK_DIV below minimum");
        end
        if (CHECK_PERIOD && SAMPLE_PERIOD < 34 * CLK_DIV + 8) begin : g_bad_period
            $error("adc_dual_capture: SAMPLE_PERIOD shorter than one frame");
        end
    endgenerate

    adc_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FB-2:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic [FB-1:0] sh1_n, sh2_n;
    logic [DATA_W-1:0] rx1_q, rx1_d, rx2_q, rx2_d;
    logic endata_q, endata_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic sclk, fall, rise, cap, b1, b2, tick, last, bad;

    // The divider is stopped on the final capture so a delayed (synchronised) capture
    // never lets an extra sclk fall escape before HOLD.
    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clock(clock),
        .reset(reset),
        .en((state_q == SETUP || state_q == SHIFT) && !last),
        .sclk(sclk),
        .fall(fall),
        .rise(rise)
    );

`ifdef ADC_SYNC_EN
    logic [1:0] m1_q, m2_q, rise_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m1_q <= '0;
            m2_q <= '0;
            rise_q <= '0;
        end else begin
            m1_q <= {m1_q[0], adc_miso1};
            m2_q <= {m2_q[0], adc_miso2};
            rise_q <= {rise_q[0], rise};
        end
    end
    assign cap = rise_q[1];
    assign b1 = m1_q[1];
    assign b2 = m2_q[1];
`else
    assign cap = rise;
    assign b1 = adc_miso1;
    assign b2 = adc_miso2;
`endif

    always_comb begin
        tick = run && timer_q == TW'(SAMPLE_PERIOD - 1);
        timer_d = tick || !run ? '0 : timer_q + 1'b1;
        sh1_n = {sh1_q, b1};
        sh2_n = {sh2_q, b2};
        sh1_d = cap ? sh1_n[FB-2:0] : sh1_q;
        sh2_d = cap ? sh2_n[FB-2:0] : sh2_q;
        last = state_q == SHIFT && cap && bit_q == BW'(FB - 1);
        bad = |sh1_n[FB-1:DATA_W] || |sh2_n[FB-1:DATA_W];
        state_d = state_q;
        bit_d = bit_q;
        rx1_d = rx1_q;
        rx2_d = rx2_q;
        endata_d = 1'b0;
        ferr_d = 1'b0;
        ovr_d = run && (ovr_q || (tick && state_q != IDLE));
        case (state_q)
            IDLE: state_d = tick ? SETUP : IDLE;
            SETUP: state_d = fall ? SHIFT : SETUP;
            SHIFT: begin
                if (cap) begin
                    bit_d = last ? '0 : bit_q + 1'b1;
                    state_d = last ? HOLD : SHIFT;
                    endata_d = last && !bad;
                    ferr_d = last && bad;
                    rx1_d = last && !bad ? sh1_n[DATA_W-1:0] : rx1_q;
                    rx2_d = last && !bad ? sh2_n[DATA_W-1:0] : rx2_q;
                end
            end
            HOLD: begin
                bit_d = bit_q == BW'(CLK_DIV - 1) ? '0 : bit_q + 1'b1;
                state_d = bit_q == BW'(CLK_DIV - 1) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
            rx1_q <= '0;
            rx2_q <= '0;
            endata_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q <= bit_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            rx1_q <= rx1_d;
            rx2_q <= rx2_d;
            endata_q <= endata_d;
            ferr_q <= ferr_d;
            ovr_q <= ovr_d;
        end
    end

    assign adc_cs_n = state_q == IDLE;
    assign adc_sclk = sclk;
    assign rx1 = rx1_q;
    assign rx2 = rx2_q;
    assign endata = endata_q;
    assign frame_err = ferr_q;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_adc_dual_capture.sv
// tb_adc_dual_capture: scoreboard bench for adc_dual_capture with a behavioural dual ADC.
// dut_a runs the nominal 1000-cycle sample period; dut_b uses a 100-cycle period so that
// ticks land while a frame is in flight.
module tb_adc_dual_capture;
    localparam int CD = 4;
`ifdef ADC_SYNC_EN
    localparam int LX = 2;
`else
    localparam int LX = 0;
`endif

    typedef struct packed {
        logic [11:0] r1;
        logic [11:0] r2;
        logic        err;
    } exp_t;

    logic clock = 1'b0, reset = 1'b1, run = 1'b0, run_b = 1'b0;
    logic cs_n, sclk, miso1 = 1'b0, miso2 = 1'b0, endata, frame_err, overrun;
    logic cs_b, sclk_b, m1_b = 1'b0, m2_b = 1'b0, en_b, fe_b, ovr_b;
    logic [11:0] rx1, rx2, rx1_b, rx2_b;
    logic [15:0] f1 = 16'h0000, f2 = 16'h0000, fb1 = 16'h0ABC, fb2 = 16'h0123;
    logic [11:0] last1 = 12'h000, last2 = 12'h000;
    int ia = 16, ib = 16, cyc = 0, checks = 0, passed = 0, last_strobe = 0;
    exp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    adc_dual_capture #(.CLK_DIV(CD), .SAMPLE_PERIOD(1000), .DATA_W(12)) dut_a (
        .clock(clock), .reset(reset), .run(run), .adc_cs_n(cs_n), .adc_sclk(sclk),
        .adc_miso1(miso1), .adc_miso2(miso2), .rx1(rx1), .rx2(rx2),
        .endata(endata), .frame_err(frame_err), .overrun(overrun)
    );

    adc_dual_capture #(.CLK_DIV(CD), .SAMPLE_PERIOD(100), .DATA_W(12), .CHECK_PERIOD(1'b0)) dut_b (
        .clock(clock), .reset(reset), .run(run_b), .adc_cs_n(cs_b), .adc_sclk(sclk_b),
        .adc_miso1(m1_b), .adc_miso2(m2_b), .rx1(rx1_b), .rx2(rx2_b),
        .endata(en_b), .frame_err(fe_b), .overrun(ovr_b)
    );

    // ADC models: next bit (MSB first) presented on every sclk fall while selected
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) ia = 16;
        else if (ia > 0) begin
            ia--;
            miso1 = f1[ia];
            miso2 = f2[ia];
        end
    end

    always @(negedge sclk_b or posedge cs_b) begin
        if (cs_b) ib = 16;
        else if (ib > 0) begin
            ib--;
            m1_b = fb1[ib];
            m2_b = fb2[ib];
        end
    end

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        f1 = a;
        f2 = b;
        e.err = (a[15:12] != 4'h0) || (b[15:12] != 4'h0);
        if (!e.err) begin
            last1 = a[11:0];
            last2 = b[11:0];
        end
        e.r1 = last1;
        e.r2 = last2;
        sb.push_back(e);
    endtask

    task automatic wait_cs_fall(input int bound, output int n);
        n = 0;
        while (cs_n !== 1'b0 && n < bound) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_strobe(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (endata !== 1'b1 && frame_err !== 1'b1 && n < bound);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if ({cs_n, sclk} !== 2'b11) $display("FAIL reset_spi cs_n/sclk got %b want 11", {cs_n, sclk}); else passed++;
        checks++; if ({rx1, rx2} !== 24'h0) $display("FAIL reset_rx got %h want 000000", {rx1, rx2}); else passed++;
        checks++; if ({endata, frame_err, overrun} !== 3'b000) $display("FAIL reset_flags got %b want 000", {endata, frame_err, overrun}); else passed++;
        checks++; if ({cs_b, en_b, ovr_b} !== 3'b100) $display("FAIL reset_b got %b want 100", {cs_b, en_b, ovr_b}); else passed++;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (cs_n !== 1'b1) $display("FAIL idle_no_run cs_n got %b want 1", cs_n); else passed++;
    endtask

    task automatic test_basic;
        int n, c0;
        exp_t e;
        push_frame(16'h0ABC, 16'h0123);
        run = 1'b1;
        wait_cs_fall(1100, n);
        c0 = cyc;
        checks++; if (n >= 1100) $display("FAIL basic_cs_fall timeout got %0d cycles want < 1100", n); else passed++;
        n = 0;
        while (sclk !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++; if (cyc - c0 != CD) $display("FAIL basic_sclk_fall got %0d want %0d", cyc - c0, CD); else passed++;
        wait_strobe(200, n);
        e = sb.pop_front();
        checks++; if (cyc - c0 != 1 + 32 * CD + LX) $display("FAIL basic_latency got %0d want %0d", cyc - c0, 1 + 32 * CD + LX); else passed++;
        checks++; if ({endata, frame_err} !== {~e.err, e.err}) $display("FAIL basic_strobe got %b want %b", {endata, frame_err}, {~e.err, e.err}); else passed++;
        checks++; if ({rx1, rx2} !== {e.r1, e.r2}) $display("FAIL basic_rx got %h/%h want %h/%h", rx1, rx2, e.r1, e.r2); else passed++;
        last_strobe = cyc;
        @(negedge clock);
        checks++; if (endata !== 1'b0) $display("FAIL basic_pulse_width endata got %b want 0", endata); else passed++;
        n = 0;
        while (cs_n !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++; if (cyc - last_strobe != CD) $display("FAIL basic_cs_rise got %0d want %0d", cyc - last_strobe, CD); else passed++;
    endtask

    task automatic test_back_to_back;
        int n;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            push_frame(i == 0 ? 16'h0555 : 16'h0FFF, i == 0 ? 16'h0AAA : 16'h0000);
            wait_strobe(1100, n);
            e = sb.pop_front();
            checks++; if (cyc - last_strobe != 1000) $display("FAIL b2b_period%0d got %0d want 1000", i, cyc - last_strobe); else passed++;
            checks++; if ({endata, frame_err} !== 2'b10) $display("FAIL b2b_strobe%0d got %b want 10", i, {endata, frame_err}); else passed++;
            checks++; if ({rx1, rx2} !== {e.r1, e.r2}) $display("FAIL b2b_rx%0d got %h/%h want %h/%h", i, rx1, rx2, e.r1, e.r2); else passed++;
            last_strobe = cyc;
        end
        checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else passed++;
    endtask

    task automatic test_frame_err;
        int n, extra;
        exp_t e;
        push_frame(16'h8FFF, 16'h0123);
        wait_strobe(1100, n);
        e = sb.pop_front();
        checks++; if (cyc - last_strobe != 1000) $display("FAIL ferr_period got %0d want 1000", cyc - last_strobe); else passed++;
        checks++; if ({endata, frame_err} !== {~e.err, e.err}) $display("FAIL ferr_strobe got %b want %b", {endata, frame_err}, {~e.err, e.err}); else passed++;
        checks++; if ({rx1, rx2} !== {e.r1, e.r2}) $display("FAIL ferr_rx_hold got %h/%h want %h/%h", rx1, rx2, e.r1, e.r2); else passed++;
        last_strobe = cyc;
        extra = 0;
        repeat (10) begin
            @(negedge clock);
            extra += int'(endata) + int'(frame_err);
        end
        checks++; if (extra != 0) $display("FAIL ferr_extra_strobes got %0d want 0", extra); else passed++;
    endtask

    task automatic test_run_drop;
        int n, c0, lows;
        exp_t e;
        push_frame(16'h0321, 16'h0765);
        wait_cs_fall(1100, n);
        c0 = cyc;
        repeat (1 + 12 * CD) @(negedge clock);
        run = 1'b0;
        wait_strobe(200, n);
        e = sb.pop_front();
        checks++; if (cyc - c0 != 1 + 32 * CD + LX) $display("FAIL drop_latency got %0d want %0d", cyc - c0, 1 + 32 * CD + LX); else passed++;
        checks++; if ({endata, frame_err} !== 2'b10) $display("FAIL drop_strobe got %b want 10", {endata, frame_err}); else passed++;
        checks++; if ({rx1, rx2} !== {e.r1, e.r2}) $display("FAIL drop_rx got %h/%h want %h/%h", rx1, rx2, e.r1, e.r2); else passed++;
        repeat (CD + 1) @(negedge clock);
        lows = 0;
        repeat (1200) begin
            @(negedge clock);
            lows += int'(!cs_n);
        end
        checks++; if (lows != 0) $display("FAIL drop_cs_idle got %0d low cycles want 0", lows); else passed++;
        checks++; if (dut_a.timer_q !== '0) $display("FAIL drop_timer got %0d want 0", dut_a.timer_q); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL drop_overrun got %b want 0", overrun); else passed++;
    endtask

    task automatic test_overrun;
        int n, s0;
        run_b = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (en_b !== 1'b1 && n < 300);
        s0 = cyc;
        checks++; if ({en_b, rx1_b, rx2_b} !== {1'b1, 12'hABC, 12'h123}) $display("FAIL ovr_first got %b %h/%h want 1 abc/123", en_b, rx1_b, rx2_b); else passed++;
        checks++; if (ovr_b !== 1'b1) $display("FAIL ovr_set got %b want 1", ovr_b); else passed++;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (en_b !== 1'b1 && n < 300);
        checks++; if (cyc - s0 != 200) $display("FAIL ovr_period got %0d want 200", cyc - s0); else passed++;
        checks++; if ({en_b, fe_b, rx1_b, rx2_b} !== {2'b10, 12'hABC, 12'h123}) $display("FAIL ovr_second got %b%b %h/%h want 10 abc/123", en_b, fe_b, rx1_b, rx2_b); else passed++;
        run_b = 1'b0;
        @(negedge clock);
        checks++; if (ovr_b !== 1'b0) $display("FAIL ovr_clear got %b want 0", ovr_b); else passed++;
    endtask

    task automatic test_reset_mid;
        int n, c0;
        exp_t e;
        push_frame(16'h0246, 16'h0135);
        run = 1'b1;
        wait_cs_fall(1100, n);
        repeat (1 + 18 * CD) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if ({cs_n, sclk} !== 2'b11) $display("FAIL rst_mid_spi got %b want 11", {cs_n, sclk}); else passed++;
        checks++; if ({rx1, rx2} !== 24'h0) $display("FAIL rst_mid_rx got %h want 000000", {rx1, rx2}); else passed++;
        sb.delete();
        last1 = 12'h000;
        last2 = 12'h000;
        @(negedge clock);
        reset = 1'b0;
        push_frame(16'h0ABC, 16'h0123);
        wait_cs_fall(1100, n);
        c0 = cyc;
        checks++; if (n >= 1100) $display("FAIL rst_mid_restart timeout got %0d want < 1100", n); else passed++;
        wait_strobe(200, n);
        e = sb.pop_front();
        checks++; if (cyc - c0 != 1 + 32 * CD + LX) $display("FAIL rst_mid_latency got %0d want %0d", cyc - c0, 1 + 32 * CD + LX); else passed++;
        checks++; if ({endata, frame_err} !== 2'b10) $display("FAIL rst_mid_strobe got %b want 10", {endata, frame_err}); else passed++;
        checks++; if ({rx1, rx2} !== {e.r1, e.r2}) $display("FAIL rst_mid_rx_after got %h/%h want %h/%h", rx1, rx2, e.r1, e.r2); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_frame_err;
        test_run_drop;
        test_overrun;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
